// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers a two-digit value from a scanned
// seven-segment display (active-low anode select + cathodes).
module ssd_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] anode,
    input  logic [6:0] port_cc,
    input  logic       err_clr,
    output logic [3:0] q1,
    output logic [3:0] q10,
    output logic [6:0] value,
    output logic       frame_stb,
    output logic       seg_err,
    output logic       an_err
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(SETTLE_CYCLES);
    localparam logic [3:0] CNT_CAP = 4'(SETTLE_CYCLES - 1);

    logic [7:0] an_r;
    logic [7:0] an_p;
    logic [6:0] seg_r;
    logic [6:0] seg_p;
    logic       clr_r;
    logic [3:0] cnt;
    state_t     state;
    logic [3:0] pend1;
    logic       have1;

    logic       changed;
    logic       sel_one;
    logic       sel_ten;
    logic       sel_ill;
    logic       legal;
    logic       seg_ok;
    logic       capture;
    logic [3:0] digit;

    // Binary value of a frame; any undecodable digit forces 127.
    function automatic logic [6:0] frame_value(
        input logic [3:0] ones,
        input logic [3:0] tens
    );
        if (ones > 4'd9 || tens > 4'd9)
            return 7'd127;
        return {3'b000, tens} * 7'd10 + {3'b000, ones};
    endfunction

    // Input registers, plus previous-cycle copies for change detection.
    // err_clr is delayed alongside so a clear lines up with an_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 8'hFF;
            seg_r <= 7'h7F;
            an_p  <= 8'hFF;
            seg_p <= 7'h7F;
            clr_r <= 1'b0;
        end else begin
            an_r  <= anode;
            seg_r <= port_cc;
            an_p  <= an_r;
            seg_p <= seg_r;
            clr_r <= err_clr;
        end
    end

    assign changed = (an_r != an_p) || (seg_r != seg_p);

    // Select decode: ones, tens, blank, or illegal.
    always_comb begin
        sel_one = 1'b0;
        sel_ten = 1'b0;
        sel_ill = 1'b0;
        unique case (1'b1)
            (an_r == 8'hFE): sel_one = 1'b1;
            (an_r == 8'hFD): sel_ten = 1'b1;
            (an_r == 8'hFF): ;
            default:         sel_ill = 1'b1;
        endcase
    end

    assign legal = sel_one | sel_ten;

    // Exact-match segment decode (g..a); anything else is 4'hF.
    always_comb begin
        digit = 4'hF;
        case (seg_r)
            7'b1000000: digit = 4'd0;
            7'b1111001: digit = 4'd1;
            7'b0100100: digit = 4'd2;
            7'b0110000: digit = 4'd3;
            7'b0011001: digit = 4'd4;
            7'b0010010: digit = 4'd5;
            7'b0000010: digit = 4'd6;
            7'b1111000: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0010000: digit = 4'd9;
            default:    digit = 4'hF;
        endcase
    end

    assign seg_ok = (digit != 4'hF);

    // Stability counter: restarts on any change, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 4'd0;
        else if (changed)
            cnt <= 4'd0;
        else if (cnt < CNT_MAX)
            cnt <= cnt + 4'd1;
    end

    // Capture fires on the edge where the count reaches the limit.
    assign capture = (state == SETTLE) && legal && !changed &&
                     (cnt == CNT_CAP);

    // Dwell FSM, digit capture, frame assembly and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend1     <= 4'd0;
            have1     <= 1'b0;
            q1        <= 4'd0;
            q10       <= 4'd0;
            value     <= 7'd0;
            frame_stb <= 1'b0;
            seg_err   <= 1'b0;
            an_err    <= 1'b0;
        end else begin
            frame_stb <= 1'b0;

            if (clr_r) begin
                seg_err <= 1'b0;
                an_err  <= 1'b0;
            end
            if (sel_ill)
                an_err <= 1'b1;
            if (capture && !seg_ok)
                seg_err <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (legal)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (!legal)
                        state <= IDLE;
                    else if (capture)
                        state <= HELD;
                end
                HELD: begin
                    if (!legal)
                        state <= IDLE;
                    else if (changed)
                        state <= SETTLE;
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                if (sel_one) begin
                    pend1 <= digit;
                    have1 <= 1'b1;
                end else if (have1) begin
                    q1        <= pend1;
                    q10       <= digit;
                    value     <= frame_value(pend1, digit);
                    frame_stb <= 1'b1;
                    have1     <= 1'b0;
                end
            end
        end
    end

endmodule
